// File: rtl/ram8_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram8_port_arbiter
// Description : Round-robin two-port arbiter in front of a single-ported
//               8-word RAM8 bank. Each transfer walks IDLE -> ACCESS -> DONE
//               and completes with a one-cycle ack to the owning port.
// Revision    : 1.0  initial release
// ============================================================================
module ram8_port_arbiter #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3     // the RAM8 bank is 8 words; only 3 is supported
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [WIDTH-1:0]  wdata0,
    output logic              ack0,
    output logic [WIDTH-1:0]  rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              ack1,
    output logic [WIDTH-1:0]  rdata1,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_in,
    input  logic [WIDTH-1:0]  mem_out,
    output logic              busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_owner;
    logic              r_we_q;
    logic              r_last;
    logic              r_mem_load;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WIDTH-1:0]  r_mem_in;
    logic              r_ack0;
    logic              r_ack1;
    logic [WIDTH-1:0]  r_rdata0;
    logic [WIDTH-1:0]  r_rdata1;

    logic              w_grant;
    logic              w_grant_port;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [WIDTH-1:0]  w_sel_wdata;
    logic [WIDTH-1:0]  w_ret_data;

    // Round-robin pick: on a conflict the port that did not win last time goes
    always_comb begin
        w_grant      = req0 | req1;
        w_grant_port = (req0 & req1) ? ~r_last : req1;
    end

    // Next-state: fixed three-cycle walk, arbitration only in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (w_grant) w_state_next = c_ACCESS;
            c_ACCESS: w_state_next = c_DONE;
            c_DONE:   w_state_next = c_IDLE;
            default:  w_state_next = c_IDLE;
        endcase
    end

    // Output selection: granted port's command and the data returned on completion
    always_comb begin
        w_sel_we    = w_grant_port ? we1    : we0;
        w_sel_addr  = w_grant_port ? addr1  : addr0;
        w_sel_wdata = w_grant_port ? wdata1 : wdata0;
        // A write echoes the committed word; a read takes the bank's mux output
        w_ret_data  = r_we_q ? r_mem_in : mem_out;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Registered bank drive, grant bookkeeping and per-port responses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner    <= 1'b0;
            r_we_q     <= 1'b0;
            r_last     <= 1'b1;
            r_mem_load <= 1'b0;
            r_mem_addr <= '0;
            r_mem_in   <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_grant) begin
                        r_owner    <= w_grant_port;
                        r_last     <= w_grant_port;
                        r_we_q     <= w_sel_we;
                        r_mem_load <= w_sel_we;
                        r_mem_addr <= w_sel_addr;
                        r_mem_in   <= w_sel_wdata;
                    end
                end
                c_ACCESS: begin
                    // The write lands in the bank on this edge; load must drop now
                    r_mem_load <= 1'b0;
                    if (r_owner) begin
                        r_rdata1 <= w_ret_data;
                        r_ack1   <= 1'b1;
                    end else begin
                        r_rdata0 <= w_ret_data;
                        r_ack0   <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                end
                default: begin
                    r_mem_load <= 1'b0;
                    r_ack0     <= 1'b0;
                    r_ack1     <= 1'b0;
                end
            endcase
        end
    end

    assign mem_load = r_mem_load;
    assign mem_addr = r_mem_addr;
    assign mem_in   = r_mem_in;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign busy     = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram8_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram8_port_arbiter
// Description : Self-checking bench for ram8_port_arbiter with a RAM8 bank
//               model and a transfer-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ram8_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [2:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, mem_load, busy;
    logic [15:0] rdata0, rdata1, mem_in, mem_out;
    logic [2:0]  mem_addr;

    int total = 0;
    int bad   = 0;

    ram8_port_arbiter #(.WIDTH(16), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1),
        .mem_load(mem_load), .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_out(mem_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM8 bank: load-routed registers with a combinational read mux
    logic [15:0] bank [8];
    always @(posedge clk) if (mem_load) bank[mem_addr] <= mem_in;
    assign mem_out = bank[mem_addr];

    // Reference model: a transfer is granted at edge g; ACCESS follows edge g,
    // DONE follows edge g+1, and a new grant may happen at edge g+3.
    logic [15:0] ref_mem [8];
    int          cyc = 0;
    int          m_g = 0;
    bit          m_busy = 0;
    bit          m_last = 1;
    bit          m_owner, m_we;
    logic [2:0]  m_addr;
    logic [15:0] m_wd;
    logic        e_load, e_ack0, e_ack1, e_busy;
    logic [2:0]  e_addr;
    logic [15:0] e_in, e_rd0, e_rd1;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        int ph;
        bit w;
        cyc++;
        e_ack0 = 1'b0;
        e_ack1 = 1'b0;
        if (!rst_n) begin
            m_busy = 0; m_last = 1;
            e_load = 0; e_addr = '0; e_in = '0; e_rd0 = '0; e_rd1 = '0; e_busy = 0;
            return;
        end
        if (m_busy && (cyc - m_g) >= 3) m_busy = 0;
        if (!m_busy && (req0 || req1)) begin
            w       = (req0 && req1) ? !m_last : req1;
            m_last  = w;
            m_owner = w;
            m_we    = w ? we1    : we0;
            m_addr  = w ? addr1  : addr0;
            m_wd    = w ? wdata1 : wdata0;
            m_g     = cyc;
            m_busy  = 1;
            e_addr  = m_addr;
            e_in    = m_wd;
            // Transfers are serialised, so committing at grant time is exact
            if (m_we) ref_mem[m_addr] = m_wd;
        end
        ph     = m_busy ? (cyc - m_g) : 2;
        e_busy = (ph <= 1);
        e_load = (ph == 0) && m_we;
        if (ph == 1) begin
            if (m_owner) begin e_ack1 = 1'b1; e_rd1 = m_we ? m_wd : ref_mem[m_addr]; end
            else         begin e_ack0 = 1'b1; e_rd0 = m_we ? m_wd : ref_mem[m_addr]; end
        end
    endtask

    task automatic check_all();
        chk("busy",     {15'd0, busy},     {15'd0, e_busy});
        chk("mem_load", {15'd0, mem_load}, {15'd0, e_load});
        chk("mem_addr", {13'd0, mem_addr}, {13'd0, e_addr});
        chk("mem_in",   mem_in,            e_in);
        chk("ack0",     {15'd0, ack0},     {15'd0, e_ack0});
        chk("ack1",     {15'd0, ack1},     {15'd0, e_ack1});
        chk("rdata0",   rdata0,            e_rd0);
        chk("rdata1",   rdata1,            e_rd1);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // Drive one command on port p and hold it until that port's ack is seen
    task automatic xfer(input bit p, input bit we, input logic [2:0] a, input logic [15:0] d);
        bit seen = 0;
        if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            seen = p ? ack1 : ack0;
        end
        chk(p ? "xfer_ack1_seen" : "xfer_ack0_seen", {15'd0, seen}, 16'd1);
        if (p) req1 = 1'b0; else req0 = 1'b0;
    endtask

    initial begin
        int q[$];
        int t0, t1, n0, n1;
        bit d0, d1, hold0, hold1;
        for (int i = 0; i < 8; i++) begin bank[i] = '0; ref_mem[i] = '0; end
        rst_n = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset state
        do_reset();
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_ack0", {15'd0, ack0}, 16'd0);

        // Single write on port 0
        req0 = 1; we0 = 1; addr0 = 3'd3; wdata0 = 16'h1234;
        tick();
        chk("sw_load_hi", {15'd0, mem_load}, 16'd1);
        chk("sw_addr",    {13'd0, mem_addr}, 16'd3);
        tick();
        chk("sw_ack0",    {15'd0, ack0}, 16'd1);
        chk("sw_load_lo", {15'd0, mem_load}, 16'd0);
        chk("sw_busy2",   {15'd0, busy}, 16'd1);
        req0 = 0;
        tick();
        chk("sw_idle",    {15'd0, busy}, 16'd0);

        // Read-back on port 1
        xfer(1'b1, 1'b0, 3'd3, 16'h0000);
        chk("rb_rdata1", rdata1, 16'h1234);
        chk("rb_rdata0", rdata0, 16'h1234);
        tick(); tick();

        // Conflict from reset: port 0 first, port 1 three cycles later
        do_reset();
        req0 = 1; we0 = 1; addr0 = 3'd1; wdata0 = 16'h00AA;
        req1 = 1; we1 = 1; addr1 = 3'd6; wdata1 = 16'h0055;
        d0 = 0; d1 = 0; t0 = 0; t1 = 0; q = {};
        for (int i = 0; i < 14 && !(d0 && d1); i++) begin
            tick();
            if (ack0 && !d0) begin d0 = 1; t0 = cyc; req0 = 0; q.push_back(0); end
            if (ack1 && !d1) begin d1 = 1; t1 = cyc; req1 = 0; q.push_back(1); end
        end
        chk("cf_both_acked", {14'd0, d1, d0}, 16'd3);
        if (q.size() > 0) chk("cf_first", 16'(q[0]), 16'd0);
        chk("cf_spacing", 16'(t1 - t0), 16'd3);
        xfer(1'b0, 1'b0, 3'd1, '0);
        chk("cf_ram1", rdata0, 16'h00AA);
        xfer(1'b0, 1'b0, 3'd6, '0);
        chk("cf_ram6", rdata0, 16'h0055);

        // Fairness: both ports read continuously for 12 cycles
        do_reset();
        req0 = 1; we0 = 0; addr0 = 3'd2;
        req1 = 1; we1 = 0; addr1 = 3'd4;
        q = {};
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack0) q.push_back(0);
            if (ack1) q.push_back(1);
        end
        req0 = 0; req1 = 0;
        chk("fair_count", 16'(q.size()), 16'd4);
        for (int i = 0; i < q.size(); i++) chk("fair_order", 16'(q[i]), 16'(i % 2));

        // Address sweep on port 0, including both ends
        for (int a = 0; a < 8; a++) xfer(1'b0, 1'b1, 3'(a), 16'h0100 + 16'(a));
        for (int a = 0; a < 8; a++) begin
            xfer(1'b0, 1'b0, 3'(a), '0);
            chk("sweep_rd", rdata0, 16'h0100 + 16'(a));
        end
        tick(); tick();

        // Reset during ACCESS of a write: no ack, write still lands
        req0 = 1; we0 = 1; addr0 = 3'd5; wdata0 = 16'hBEEF;
        tick();
        chk("rm_access", {15'd0, mem_load}, 16'd1);
        rst_n = 0; req0 = 0;
        tick();
        chk("rm_ack0", {15'd0, ack0}, 16'd0);
        chk("rm_busy", {15'd0, busy}, 16'd0);
        chk("rm_load", {15'd0, mem_load}, 16'd0);
        rst_n = 1;
        tick();
        xfer(1'b1, 1'b0, 3'd5, '0);
        chk("rm_rd5", rdata1, 16'hBEEF);

        // Randomized traffic with occasional resets
        hold0 = 0; hold1 = 0; n0 = 0; n1 = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (ack0) begin hold0 = 0; n0++; end
            if (ack1) begin hold1 = 0; n1++; end
            if (!hold0) begin
                if ($urandom_range(0, 2) != 0) begin
                    req0 = 1; we0 = 1'($urandom); addr0 = 3'($urandom); wdata0 = 16'($urandom); hold0 = 1;
                end else req0 = 0;
            end
            if (!hold1) begin
                if ($urandom_range(0, 2) != 0) begin
                    req1 = 1; we1 = 1'($urandom); addr1 = 3'($urandom); wdata1 = 16'($urandom); hold1 = 1;
                end else req1 = 0;
            end
            rst_n = ($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1;
        end
        chk("rand_progress", {14'd0, (n1 > 0), (n0 > 0)}, 16'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
